// File: rtl/alu_issue_stage_if.sv
// ALU op encoding shared by the issue stage and its neighbours, plus the
// fetch-side / execute-side bus bundle of the issue stage.
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_t;
endpackage

interface alu_issue_stage_if #(parameter int XLEN = 32);
  import alu_issue_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  alu_t            out_op;
  logic [XLEN-1:0] out_opA;
  logic [XLEN-1:0] out_opB;
  logic [4:0]      out_rd;
  logic            out_we;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  // slave: the issue stage itself
  modport slave (
    input  flush, in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_opA, out_opB,
           out_rd, out_we, out_pc, out_illegal
  );

  // master: fetch + regfile + execute environment around the stage
  modport master (
    output flush, in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_opA, out_opB,
           out_rd, out_we, out_pc, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I integer decode/issue stage: decodes OP/OP-IMM/LUI/AUIPC into an ALU op
// with operands and holds it in a single backpressured output register.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  alu_issue_stage_if.slave bus
);

  typedef struct packed {
    alu_t            op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } dec_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [31:0]     instr;
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  dec_t            dec;
  dec_t            out_q;
  logic [1:0]      vld_pipe;
  logic            accept;

  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign shamt = {{(XLEN-5){1'b0}}, instr[24:20]};

  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  always_comb begin
    alu_t            op;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            legal;
    op    = ALU_ADD;
    opa   = '0;
    opb   = '0;
    legal = 1'b1;
    unique case (opc)
      OPC_OP: begin
        opa = bus.rs1_data;
        opb = bus.rs2_data;
        case ({f7, f3})
          {F7_BASE, 3'b000}: op = ALU_ADD;
          {F7_ALT,  3'b000}: op = ALU_SUB;
          {F7_BASE, 3'b001}: op = ALU_SLL;
          {F7_BASE, 3'b010}: op = ALU_SLT;
          {F7_BASE, 3'b011}: op = ALU_SLTU;
          {F7_BASE, 3'b100}: op = ALU_XOR;
          {F7_BASE, 3'b101}: op = ALU_SRL;
          {F7_ALT,  3'b101}: op = ALU_SRA;
          {F7_BASE, 3'b110}: op = ALU_OR;
          {F7_BASE, 3'b111}: op = ALU_AND;
          default:           legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        opa = bus.rs1_data;
        opb = imm_i;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            opb = shamt;
            if (f7 == F7_BASE) op = ALU_SLL;
            else               legal = 1'b0;
          end
          default: begin
            // funct3 101: RV32 shamt is 5 bits, so instr[25] must be clear
            opb = shamt;
            if (f7 == F7_BASE)     op = ALU_SRL;
            else if (f7 == F7_ALT) op = ALU_SRA;
            else                   legal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        opa = '0;
        opb = imm_u;
      end
      OPC_AUIPC: begin
        opa = bus.in_pc;
        opb = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      op  = ALU_ADD;
      opa = '0;
      opb = '0;
    end
    dec.op  = op;
    dec.opa = opa;
    dec.opb = opb;
    dec.rd  = instr[11:7];
    dec.we  = legal && (instr[11:7] != 5'd0);
    dec.ill = !legal;
  end

  assign bus.in_ready = !vld_pipe[1] || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // flush kills a same-cycle accept without touching in_ready
  assign vld_pipe[0]  = accept && !bus.flush;

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      out_q       <= '{op: ALU_ADD, opa: '0, opb: '0, rd: '0, we: 1'b0, ill: 1'b0};
      pc_q        <= '0;
    end else if (bus.flush) begin
      vld_pipe[1] <= 1'b0;
    end else if (accept) begin
      vld_pipe[1] <= 1'b1;
      out_q       <= dec;
      pc_q        <= bus.in_pc;
    end else if (bus.out_ready) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_pipe[1];
  assign bus.out_op      = out_q.op;
  assign bus.out_opA     = out_q.opa;
  assign bus.out_opB     = out_q.opb;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_we      = out_q.we;
  assign bus.out_illegal = out_q.ill;
  assign bus.out_pc      = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush, reset.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_issue_stage_if #(.XLEN(32)) bus ();
  alu_issue_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic chk_out(input string tag, input alu_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic we, input logic ill);
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".op"},  32'(bus.out_op), 32'(op));
    chk({tag, ".opA"}, bus.out_opA, a);
    chk({tag, ".opB"}, bus.out_opB, b);
    chk({tag, ".rd"},  32'(bus.out_rd), 32'(rd));
    chk({tag, ".we"},  32'(bus.out_we), 32'(we));
    chk({tag, ".ill"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".op"},  32'(bus.out_op), 32'(ALU_ADD));
    chk({tag, ".opA"}, bus.out_opA, 32'd0);
    chk({tag, ".opB"}, bus.out_opB, 32'd0);
    chk({tag, ".pc"},  bus.out_pc, 32'd0);
    chk({tag, ".rd"},  32'(bus.out_rd), 32'd0);
    chk({tag, ".we"},  32'(bus.out_we), 32'd0);
    chk({tag, ".ill"}, 32'(bus.out_illegal), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;

    // add x3,x1,x2
    drive(32'h002081B3, 32'h40, 32'd5, 32'd7);
    #1;
    chk("add.rs1a", 32'(bus.rs1_addr), 32'd1);
    chk("add.rs2a", 32'(bus.rs2_addr), 32'd2);
    chk("add.inrdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("add", ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    chk("add.pc", bus.out_pc, 32'h40);

    // back-to-back stream, one instruction per cycle
    drive(32'h0020C1B3, 32'h44, 32'hF0F0_0000, 32'h0FF0_0000); tick();
    chk_out("xor", ALU_XOR, 32'hF0F0_0000, 32'h0FF0_0000, 5'd3, 1'b1, 1'b0);
    drive(32'hFFF00293, 32'h48, 32'd0, 32'd0); tick();
    chk_out("addi", ALU_ADD, 32'd0, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    drive(32'h4033D313, 32'h4C, 32'h8000_0000, 32'd0); tick();
    chk_out("srai", ALU_SRA, 32'h8000_0000, 32'd3, 5'd6, 1'b1, 1'b0);
    drive(32'h0200D313, 32'h50, 32'h1234, 32'd0); tick();
    chk_out("srli25", ALU_ADD, 32'd0, 32'd0, 5'd6, 1'b0, 1'b1);
    drive(32'h042081B3, 32'h54, 32'd1, 32'd2); tick();
    chk_out("badf7", ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
    drive(32'h00000003, 32'h58, 32'd1, 32'd2); tick();
    chk_out("badopc", ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    drive(32'h123450B7, 32'h5C, 32'hDEAD, 32'hBEEF); tick();
    chk_out("lui", ALU_ADD, 32'd0, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
    drive(32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF); tick();
    chk_out("auipc", ALU_ADD, 32'h100, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
    chk("auipc.pc", bus.out_pc, 32'h100);

    // backpressure: add held while addi x5,x0,10 waits
    drive(32'h002081B3, 32'h200, 32'd1, 32'd2); tick();
    bus.out_ready = 1'b0;
    drive(32'h00A00293, 32'h204, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.inrdy", 32'(bus.in_ready), 32'd0);
      tick();
      chk_out("bp.hold", ALU_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
      chk("bp.pc", bus.out_pc, 32'h200);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.inrdy1", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("bp.next", ALU_ADD, 32'd0, 32'd10, 5'd5, 1'b1, 1'b0);
    chk("bp.nextpc", bus.out_pc, 32'h204);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.drain", 32'(bus.out_valid), 32'd0);

    // flush during an accept while a valid op is held
    drive(32'h002081B3, 32'h300, 32'd1, 32'd2); tick();
    chk("fl.pre", 32'(bus.out_valid), 32'd1);
    drive(32'h40208033, 32'h304, 32'd9, 32'd4);
    bus.flush = 1'b1;
    #1;
    chk("fl.inrdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("fl.vld", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("fl.drop", 32'(bus.out_valid), 32'd0);

    // sub x0,x1,x2: op and operands still produced, no writeback
    drive(32'h40208033, 32'h308, 32'd9, 32'd4); tick();
    chk_out("subx0", ALU_SUB, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;

    // reset while stalled with a valid op
    drive(32'h002081B3, 32'h400, 32'd5, 32'd7); tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(32'h123450B7, 32'h404, 32'd0, 32'd0); tick();
    chk_out("resume", ALU_ADD, 32'd0, 32'h1234_5000, 5'd1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that feeds the integer ALU.
- Accepts a fetched RV32I instruction with its PC over a valid/ready handshake and reads rs1/rs2 from the register file.
- Translates the instruction into an alu_t operation plus the opA/opB operands and writeback control.
- Holds the result in an output pipeline register with backpressure and flush support.
- Sits between fetch and the execute stage that instantiates the ALU.

Parameters:
- XLEN, 32, datapath width of the pc, rs data, operands and immediates. Only 32 is supported; shift-immediate legality assumes RV32.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard the held instruction (branch redirect/trap)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  XLEN  PC of in_instr
- rs1_addr  output  5  combinational, = in_instr[19:15]
- rs2_addr  output  5  combinational, = in_instr[24:20]
- rs1_data  input  XLEN  register file read data for rs1_addr, same cycle
- rs2_data  input  XLEN  register file read data for rs2_addr, same cycle
- out_valid  output  1  issued ALU operation valid
- out_ready  input  1  execute stage accepts
- out_op  output  alu_t  ALU operation
- out_opA  output  XLEN  ALU operand A
- out_opB  output  XLEN  ALU operand B
- out_rd  output  5  destination register
- out_we  output  1  register writeback enable
- out_pc  output  XLEN  PC of the issued instruction
- out_illegal  output  1  instruction not decodable by this stage

Behaviour:
- **Reset** (rst=1 at edge): out_valid=0, out_op=ALU_ADD, out_opA/opB/pc=0, out_rd=0, out_we=0, out_illegal=0. rst overrides flush and any handshake.
- **Handshake:**
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. On acceptance the decoded fields load into the output register next edge, and out_valid=1.
  - If out_valid && out_ready and no accept: out_valid=0 next edge.
  - If out_valid && !out_ready: all out_* are held bit-stable.
  - Latency: 1 cycle. Full throughput of 1/cycle with out_ready held 1.
- **Flush:** flush=1 at edge forces out_valid=0 and blocks a same-cycle accept; the incoming instruction is dropped. in_ready is not gated by flush.
- **Decode, opcode 0110011 (R-type):** opA=rs1_data, opB=rs2_data. The funct7/funct3 mapping is:
  - 0000000/000 ADD
  - 0100000/000 SUB
  - 0000000/001 SLL
  - 0000000/010 SLT
  - 0000000/011 SLTU
  - 0000000/100 XOR
  - 0000000/101 SRL
  - 0100000/101 SRA
  - 0000000/110 OR
  - 0000000/111 AND
  - Any other combination is illegal.
- **Decode, opcode 0010011 (I-type):** opA=rs1_data, opB=sign-extended instr[31:20]. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - Shifts use opB={27'b0, instr[24:20]}.
  - funct3 001 with instr[31:25]=0000000 is SLL.
  - funct3 101 with instr[31:25]=0000000 is SRL; with 0100000 it is SRA.
  - Any other shift encoding, including instr[25]=1, is illegal.
- **Decode, opcode 0110111 (LUI):** op ADD, opA=0, opB={instr[31:12],12'b0}.
- **Decode, opcode 0010111 (AUIPC):** op ADD, opA=in_pc, opB={instr[31:12],12'b0}.
- **Illegal instruction** (any other opcode, or a bad funct): out_illegal=1, out_op=ALU_ADD, opA=opB=0, out_we=0. The instruction still flows through the handshake.
- **Writeback:**
  - out_rd=instr[11:7].
  - out_we=1 only for legal instructions with rd≠0. rd=0 gives out_we=0, with op and operands still produced.
- **Other:** no hazard/forwarding logic. rs data is captured as presented in the accept cycle.

Test Plan:
- **R-type ADD:** in_instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7, out_ready=1 → next cycle out_valid=1, out_op=ALU_ADD, opA=5, opB=7, rd=3, we=1, illegal=0; rs1_addr=1, rs2_addr=2 in the accept cycle.
- **I-type immediate and shift:**
  - 0xFFF00293 (addi x5,x0,-1) → ALU_ADD, opB=0xFFFFFFFF, rd=5.
  - 0x4033D313 (srai x6,x7,3) → ALU_SRA, opB=3.
  - 0x0200D313 (srli with instr[25]=1) → out_illegal=1, we=0.
- **U-type:**
  - 0x123450B7 (lui x1,0x12345) → opA=0, opB=0x12345000.
  - AUIPC 0x12345097 with in_pc=0x100 → opA=0x100, opB=0x12345000.
- **Backpressure:**
  - Issue add, then hold out_ready=0 for 3 cycles with a new in_valid → in_ready=0, outputs unchanged for 3 cycles.
  - Raise out_ray=1 → second instruction appears the following cycle, none lost or duplicated.
- **Flush and rd=0:**
  - flush=1 in the same cycle as an accept while out_valid=1 → next cycle out_valid=0, the incoming instruction is dropped.
  - sub x0,x1,x2 (0x40208033) → out_op=ALU_SUB, we=0.
- **Reset mid-stream:** rst=1 while out_valid=1 && out_ready=0 → next cycle out_valid=0, all outputs at reset values; normal issue resumes the cycle after rst drops.
